// File: rtl/rr_arbiter_2pn_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding, hold-counter width
// and the requester-count derivation R = 2**N.
package rr_arbiter_2pn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned HOLD_W = 16;

  function automatic int unsigned num_req(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/decoder_Nx2pN.sv
// N-to-2**N one-hot decoder used to drive decoder-selected bus ports.
// Purely combinational, no backpressure.
module decoder_Nx2pN #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]      idx_i,
  output logic [2**N-1:0]   dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_2pn.sv
// Round-robin arbiter for 2**N requesters with ownership until release and an optional
// hold limit. Grant latency 1 cycle; release-to-new-grant 1 cycle, back to back.
module rr_arbiter_2pn
  import rr_arbiter_2pn_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned R       = num_req(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [R-1:0] req_i,
  input  logic         done_i,
  output logic [R-1:0] gnt_o,
  output logic [N-1:0] gnt_idx_o,
  output logic         gnt_valid_o,
  output logic         timeout_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [N-1:0]      idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              win_vld;
  logic [N-1:0]      win_idx;
  logic              owner_wd;
  logic              lim_hit;
  logic              grant_new;
  logic [R-1:0]      dec;

  // First set bit at or above ptr, wrapping at R; MSB of the result flags a hit.
  function automatic logic [N:0] ffs_rot(input logic [R-1:0] req, input logic [N-1:0] ptr);
    logic [N-1:0] idx;
    logic [N:0]   res;
    res = '0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = ptr + N'(k);
      if (!res[N] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {win_vld, win_idx} = ffs_rot(req_i, ptr_q);
  assign owner_wd = !req_i[idx_q];
  assign lim_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    grant_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) grant_new = 1'b1;
      end
      BUSY: begin
        if (done_i || owner_wd || lim_hit) begin
          // DONE and withdrawal take precedence over the limit for the pulse
          timeout_d = lim_hit && !done_i && !owner_wd;
          if (win_vld) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      state_d = BUSY;
      idx_d   = win_idx;
      ptr_d   = win_idx + N'(1);
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  decoder_Nx2pN #(.N(N)) u_dec (
    .idx_i (idx_q),
    .dec_o (dec)
  );

  assign gnt_valid_o = (state_q == BUSY);
  assign gnt_idx_o   = idx_q;
  assign timeout_o   = timeout_q;
  assign gnt_o       = dec & {R{gnt_valid_o}};

endmodule

// File: tb/tb_rr_arbiter_2pn.sv
// Bench for rr_arbiter_2pn: two instances (no hold limit, hold limit 4) share stimulus
// and are compared each cycle against an integer-level reference model.
module tb_rr_arbiter_2pn;

  localparam int R = 4;

  logic         clk;
  logic         rst_n;
  logic [R-1:0] req;
  logic         done;

  logic [R-1:0] gnt_a, gnt_b;
  logic [1:0]   idx_a, idx_b;
  logic         vld_a, vld_b;
  logic         to_a, to_b;

  int n_chk = 0;
  int n_err = 0;

  // Reference state per instance: owner -1 means no grant.
  int own [2];
  int ptr [2];
  int hold[2];
  bit tmo [2];
  int mh  [2] = '{0, 4};

  rr_arbiter_2pn #(.N(2), .MAX_HOLD(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt_a), .gnt_idx_o(idx_a), .gnt_valid_o(vld_a), .timeout_o(to_a)
  );

  rr_arbiter_2pn #(.N(2), .MAX_HOLD(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt_b), .gnt_idx_o(idx_b), .gnt_valid_o(vld_b), .timeout_o(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; ptr[d] = 0; hold[d] = 0; tmo[d] = 1'b0;
    end
  endtask

  task automatic model_grant(input int d);
    int w;
    w = -1;
    for (int k = 0; k < R; k++) begin
      int i;
      i = (ptr[d] + k) % R;
      if (w < 0 && req[i]) w = i;
    end
    if (w < 0) begin
      own[d] = -1;
    end else begin
      own[d]  = w;
      ptr[d]  = (w + 1) % R;
      hold[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit at_lim, rel;
    tmo[d] = 1'b0;
    if (own[d] < 0) begin
      if (req != 0) model_grant(d);
    end else begin
      at_lim = (mh[d] != 0) && (hold[d] == mh[d] - 1);
      rel    = done || !req[own[d]] || at_lim;
      if (rel) begin
        tmo[d] = at_lim && !done && req[own[d]];
        model_grant(d);
      end else if (hold[d] < 65535) begin
        hold[d]++;
      end
    end
  endtask

  task automatic check_outs();
    logic [R-1:0] eg;
    eg = (own[0] < 0) ? '0 : R'(1 << own[0]);
    chk_eq("a_gnt", gnt_a, eg);
    chk_eq("a_idx", idx_a, (own[0] < 0) ? 0 : own[0]);
    chk_eq("a_vld", vld_a, own[0] >= 0);
    chk_eq("a_tmo", to_a, tmo[0]);
    eg = (own[1] < 0) ? '0 : R'(1 << own[1]);
    chk_eq("b_gnt", gnt_b, eg);
    chk_eq("b_idx", idx_b, (own[1] < 0) ? 0 : own[1]);
    chk_eq("b_vld", vld_b, own[1] >= 0);
    chk_eq("b_tmo", to_b, tmo[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #3;
    chk_eq("rst_gnt", {gnt_a, gnt_b}, 8'h00);
    chk_eq("rst_vld", {vld_a, vld_b, to_a, to_b}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Idle with no requests stays idle
    repeat (4) tick();
    chk_eq("idle_vld", vld_a, 1'b0);

    // Single requester, re-granted after DONE as sole requester
    req = 4'b0100;
    tick();
    chk_eq("single_gnt", gnt_a, 4'b0100);
    chk_eq("single_idx", idx_a, 2);
    done = 1'b1;
    tick();
    chk_eq("single_regnt", gnt_a, 4'b0100);
    done = 1'b0;

    // Rotation with DONE every cycle
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    tick(); chk_eq("rot0", gnt_a, 4'b0001);
    tick(); chk_eq("rot1", gnt_a, 4'b0010);
    tick(); chk_eq("rot2", gnt_a, 4'b0100);
    tick(); chk_eq("rot3", gnt_a, 4'b1000);
    tick(); chk_eq("rot4", gnt_a, 4'b0001);
    done = 1'b0;

    // Hold limit of 4 on instance b
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_eq("hold_own0", {gnt_b, to_b}, {4'b0001, 1'b0});
    end
    tick();
    chk_eq("hold_sw1", {gnt_b, to_b}, {4'b0010, 1'b1});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_eq("hold_own1", {gnt_b, to_b}, {4'b0010, 1'b0});
    end
    tick();
    chk_eq("hold_sw0", {gnt_b, to_b}, {4'b0001, 1'b1});
    chk_eq("nolimit_a", gnt_a, 4'b0001);

    // Withdrawal by owner 3 with others pending, then with nobody pending
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b0101;
    tick();
    chk_eq("wd_wrap", gnt_a, 4'b0001);
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    chk_eq("wd_idle", {vld_a, idx_a}, 3'b000);

    // Asynchronous reset mid-grant
    req = 4'b0110;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_eq("arst_gnt", {gnt_a, gnt_b}, 8'h00);
    chk_eq("arst_vld", {vld_a, vld_b}, 2'b00);
    req = 4'b1000;
    #1;
    rst_n = 1'b1;
    tick();
    chk_eq("arst_first", gnt_a, 4'b1000);

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = R'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_2pn.md
# rr_arbiter_2pn

- Round-robin arbiter sharing one resource among 2**N requesters.
- Holds an N-bit registered owner index and drives the one-hot grant vector from it through the team's N-to-2**N decoder.
- Sits in front of any shared bus or port whose select lines are decoder-driven.
- Provides ownership until release, plus an optional hold-time limit, so no requester starves.

## Interface
- N, default 2: requester index width; number of requesters R = 2**N.
- MAX_HOLD, default 0: maximum grant length in cycles; 0 disables the limit; otherwise 1..2**16-1.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- REQ  in  R  per-requester request level; bit i belongs to requester i.
- DONE  in  1  owner release strobe; ignored when no grant is active.
- GNT  out  R  one-hot grant; all zero when no grant is active.
- GNT_IDX  out  N  index of the current owner; 0 when no grant is active.
- GNT_VALID  out  1  high while a grant is active.
- TIMEOUT  out  1  one-cycle pulse in the cycle a hold-limit release occurs.

## Operation
- **Reset values:** state IDLE, PTR=0, GNT_IDX=0, GNT_VALID=0, GNT=0, hold counter=0, TIMEOUT=0.
- **States:**
  - IDLE: no owner.
  - BUSY: owner = GNT_IDX.
- **Arbitration:** the winner is the first set bit of REQ, searching upward from PTR and wrapping from R-1 to 0.
- **Pointer update:** on each new grant, PTR <= winner+1, modulo R (natural wrap at N bits).
- **IDLE -> BUSY:** when any REQ bit is set. The winner is registered into GNT_IDX and GNT_VALID=1. Hold counter <= 0.
- **Release in BUSY:** any one of the following releases the grant:
  - DONE=1;
  - REQ[GNT_IDX]=0 (owner withdrew);
  - MAX_HOLD!=0 and hold counter == MAX_HOLD-1.
- **BUSY, no release:** stay in BUSY; hold counter increments and saturates at 2**16-1.
- **Release with REQ set:** arbitrate on the REQ of the release cycle and go directly to BUSY with the new winner, back to back with no idle cycle.
  - The old owner is searched last because PTR already points past it.
  - It is re-granted only if it is the sole requester. The hold counter restarts at 0.
- **Release with REQ all zero:** go to IDLE with GNT_VALID=0 and GNT_IDX=0.
- **TIMEOUT:**
  - Registered pulse, high for exactly the cycle after the limit release edge, aligned with the new grant.
  - Not raised if DONE or owner withdrawal coincide with the limit; DONE takes priority.
- **GNT derivation:** GNT = decode(GNT_IDX) AND {R{GNT_VALID}}. It is purely combinational from registers, so there is no glitch from REQ.
- **Fairness:** any requester holding REQ is granted within R-1 intervening grants.
- **Reset mid-grant:** outputs clear asynchronously and immediately; PTR returns to 0.

## Timing
- **Grant latency from IDLE:** 1 cycle. A REQ sampled at edge k gives GNT valid after edge k, visible in cycle k+1.
- **Release-to-new-grant:** 1 cycle. DONE sampled at edge k means the new owner is visible after edge k.
- **Owner visibility:** an owner sees GNT for at least 1 cycle. DONE asserted in the first grant cycle releases at the next edge.
- **Hold-limit timing:** with MAX_HOLD=M, a continuously requesting owner with other requesters pending holds GNT for exactly M cycles.
- **Registered outputs:** all outputs except GNT are flops. GNT is the decoder output of registered signals.

## Structure
- **Shared package/header:** state encoding (IDLE=1'b0, BUSY=1'b1), the hold-counter width constant HOLD_W=16, and the R = 2**N derivation.
- **Sub-module:** instantiate decoder_Nx2pN with parameter N, driven by GNT_IDX, with its output ANDed with GNT_VALID.
- **Priority search:** a rotating find-first-set function is local to this module.

## Test plan
- **Reset:** N=2, MAX_HOLD=0; reset released with REQ=0000 -> GNT=0000, GNT_VALID=0, GNT_IDX=0 indefinitely.
- **Single requester:** REQ=0100 from IDLE -> next cycle GNT=0100, GNT_IDX=2. DONE pulse -> since REQ[2] is still set and is the sole requester, it is re-granted (GNT=0100) on the next cycle.
- **Rotation:** REQ=1111 held, DONE pulsed every cycle -> GNT sequence 0001, 0010, 0100, 1000, 0001, with no idle gap.
- **Hold limit:** MAX_HOLD=4, REQ=0011, no DONE ->
  - GNT=0001 for exactly 4 cycles, then GNT=0010 with TIMEOUT=1 for one cycle;
  - repeats alternately.
- **Withdrawal:** owner 3 drops REQ[3] while REQ=0101 -> next cycle GNT=0001 (PTR wrapped to 0). If REQ=0000 instead -> GNT_VALID=0.
- **Async reset mid-grant:** RSTn low mid-cycle during BUSY -> GNT and GNT_VALID go 0 without a clock edge. After release with REQ=1000 -> first grant is 1000, searched from PTR=0.
